// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA video-memory write path.
//   - Active-area limits for the two supported resolutions
//   - Coordinate and colour widths used on every write port
//   - Scheduler state enum
//   - xMaxFor/yMaxFor map a resolution string onto its active-area limits
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int X_MAX_320 = 320;
  localparam int Y_MAX_240 = 240;
  localparam int X_MAX_160 = 160;
  localparam int Y_MAX_120 = 120;

  localparam int COORD_X_W   = 9;
  localparam int COORD_Y_W   = 8;
  localparam int COLOUR_W    = 12;

  // Resolution strings are seven characters, carried as 56-bit vectors.
  localparam int RES_W = 56;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  // Anything other than the low resolution falls back to the full one.
  function automatic int xMaxFor(input logic [RES_W-1:0] res);
    return (res == "160x120") ? X_MAX_160 : X_MAX_320;
  endfunction

  function automatic int yMaxFor(input logic [RES_W-1:0] res);
    return (res == "160x120") ? Y_MAX_120 : Y_MAX_240;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin decision, purely combinational.
//   enable_i      : arbitration allowed this cycle
//   req0_i/req1_i : requests
//   last_i        : index of the requester granted most recently
//   gnt0_o/gnt1_o : one-hot (or zero) grant
//   last_o        : pointer value after this cycle's grant
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic enable_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic last_o
);

  // On contention the requester that did not win last time goes first.
  assign gnt0_o = enable_i & req0_i & (~req1_i | last_i);
  assign gnt1_o = enable_i & req1_i & (~req0_i | ~last_i);

  // The pointer only moves when someone is actually granted.
  assign last_o = gnt0_o ? 1'b0 : (gnt1_o ? 1'b1 : last_i);

endmodule

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
// Merges two pixel requesters and a full-screen fill engine onto a single
// registered video-memory write port.
//   vga_clock, resetn          : clock, async active-low reset
//   req0/1, x0/1, y0/1, c0/1   : requester pixels (held until granted)
//   gnt0/1                     : combinational grant, pixel consumed that cycle
//   clear_req, clear_colour    : start a fill with the given colour
//   clear_busy                 : fill in progress
//   out_x/out_y/out_colour     : registered write-port data
//   out_plot                   : registered write enable
//   oob                        : pulse for a granted but off-screen pixel
// ---------------------------------------------------------------------------
module vram_write_scheduler
  import vga_pkg::*;
#(
  parameter logic [RES_W-1:0] RESOLUTION  = "320x240",
  parameter int               COLOUR_BITS = 12
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [COORD_X_W-1:0]   x0,
  input  logic [COORD_X_W-1:0]   x1,
  input  logic [COORD_Y_W-1:0]   y0,
  input  logic [COORD_Y_W-1:0]   y1,
  input  logic [COLOUR_BITS-1:0] c0,
  input  logic [COLOUR_BITS-1:0] c1,
  output logic                   gnt0,
  output logic                   gnt1,
  input  logic                   clear_req,
  input  logic [COLOUR_BITS-1:0] clear_colour,
  output logic                   clear_busy,
  output logic [COORD_X_W-1:0]   out_x,
  output logic [COORD_Y_W-1:0]   out_y,
  output logic [COLOUR_BITS-1:0] out_colour,
  output logic                   out_plot,
  output logic                   oob
);

  localparam logic [COORD_X_W-1:0] XMax  = COORD_X_W'(xMaxFor(RESOLUTION));
  localparam logic [COORD_Y_W-1:0] YMax  = COORD_Y_W'(yMaxFor(RESOLUTION));
  localparam logic [COORD_X_W-1:0] XLast = COORD_X_W'(xMaxFor(RESOLUTION) - 1);
  localparam logic [COORD_Y_W-1:0] YLast = COORD_Y_W'(yMaxFor(RESOLUTION) - 1);

  state_e                 state_q, state_d;
  logic [COORD_X_W-1:0]   sweepX_q, sweepX_d;
  logic [COORD_Y_W-1:0]   sweepY_q, sweepY_d;
  logic [COLOUR_BITS-1:0] fillColour_q, fillColour_d;
  logic [COORD_X_W-1:0]   outX_q, outX_d;
  logic [COORD_Y_W-1:0]   outY_q, outY_d;
  logic [COLOUR_BITS-1:0] outColour_q, outColour_d;
  logic                   outPlot_q, outPlot_d;
  logic                   oob_q, oob_d;
  logic                   clearBusy_q, clearBusy_d;
  logic                   lastGnt_q, lastGnt_d;

  logic                   arbEnable;
  logic [COORD_X_W-1:0]   selX;
  logic [COORD_Y_W-1:0]   selY;
  logic [COLOUR_BITS-1:0] selColour;
  logic                   selInRange;

  // A pending clear wins over the requesters, and nobody is granted mid-fill.
  assign arbEnable = (state_q == IDLE) && !clear_req;

  rr_arbiter2 u_arb (
    .enable_i (arbEnable),
    .req0_i   (req0),
    .req1_i   (req1),
    .last_i   (lastGnt_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .last_o   (lastGnt_d)
  );

  assign selX       = gnt0 ? x0 : x1;
  assign selY       = gnt0 ? y0 : y1;
  assign selColour  = gnt0 ? c0 : c1;
  assign selInRange = (selX < XMax) && (selY < YMax);

  // Next-state logic: the write port holds its data unless a granted pixel
  // or a fill pixel replaces it; the enable and oob pulse default low.
  always_comb begin
    state_d      = state_q;
    sweepX_d     = sweepX_q;
    sweepY_d     = sweepY_q;
    fillColour_d = fillColour_q;
    outX_d       = outX_q;
    outY_d       = outY_q;
    outColour_d  = outColour_q;
    outPlot_d    = 1'b0;
    oob_d        = 1'b0;
    clearBusy_d  = clearBusy_q;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d      = CLEAR;
          fillColour_d = clear_colour;
          sweepX_d     = '0;
          sweepY_d     = '0;
          clearBusy_d  = 1'b1;
        end else if (gnt0 || gnt1) begin
          // Off-screen pixels are still consumed so the requester is not stuck.
          outX_d      = selX;
          outY_d      = selY;
          outColour_d = selColour;
          outPlot_d   = selInRange;
          oob_d       = !selInRange;
        end
      end
      CLEAR: begin
        outX_d      = sweepX_q;
        outY_d      = sweepY_q;
        outColour_d = fillColour_q;
        outPlot_d   = 1'b1;
        if ((sweepX_q == XLast) && (sweepY_q == YLast)) begin
          state_d     = IDLE;
          clearBusy_d = 1'b0;
        end else if (sweepX_q == XLast) begin
          sweepX_d = '0;
          sweepY_d = sweepY_q + 1'b1;
        end else begin
          sweepX_d = sweepX_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and write-port registers; reset aborts any fill immediately.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sweepX_q     <= '0;
      sweepY_q     <= '0;
      fillColour_q <= '0;
      outX_q       <= '0;
      outY_q       <= '0;
      outColour_q  <= '0;
      outPlot_q    <= 1'b0;
      oob_q        <= 1'b0;
      clearBusy_q  <= 1'b0;
      lastGnt_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      sweepX_q     <= sweepX_d;
      sweepY_q     <= sweepY_d;
      fillColour_q <= fillColour_d;
      outX_q       <= outX_d;
      outY_q       <= outY_d;
      outColour_q  <= outColour_d;
      outPlot_q    <= outPlot_d;
      oob_q        <= oob_d;
      clearBusy_q  <= clearBusy_d;
      lastGnt_q    <= lastGnt_d;
    end
  end

  assign out_x      = outX_q;
  assign out_y      = outY_q;
  assign out_colour = outColour_q;
  assign out_plot   = outPlot_q;
  assign oob        = oob_q;
  assign clear_busy = clearBusy_q;

endmodule

// File: doc/vram_write_scheduler.md
VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 Parameter RESOLUTION, default "320x240", legal values "320x240" or "160x120", selects the active X/Y range.
REQ-002 Parameter COLOUR_BITS, default 12, gives the colour width as R[11:8], G[7:4], B[3:0].
REQ-003 vga_clock  in  1  clock; all logic is posedge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  in  1  write request from requester 0 / 1; held high until granted.
REQ-006 x0 / x1  in  9  pixel X of requester 0 / 1; held stable while req is high.
REQ-007 y0 / y1  in  8  pixel Y of requester 0 / 1; held stable while req is high.
REQ-008 c0 / c1  in  COLOUR_BITS  pixel colour of requester 0 / 1.
REQ-009 gnt0 / gnt1  out  1  combinational one-cycle grant; the pixel is consumed in that cycle.
REQ-010 clear_req  in  1  pulse that starts a full-screen fill.
REQ-011 clear_colour  in  COLOUR_BITS  fill colour, sampled in the clear_req acceptance cycle.
REQ-012 clear_busy  out  1  registered; high while a fill is in progress.
REQ-013 out_x  out  9  registered X to the video memory write port.
REQ-014 out_y  out  8  registered Y to the video memory write port.
REQ-015 out_colour  out  COLOUR_BITS  registered colour to the video memory write port.
REQ-016 out_plot  out  1  registered write enable to the video memory write port.
REQ-017 oob  out  1  registered one-cycle pulse flagging a dropped out-of-range pixel.

Function
REQ-018 X_MAX/Y_MAX SHALL be 320/240 for "320x240" and 160/120 for "160x120"; ports are always 9/8 bits wide.
REQ-019 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-020 In IDLE, a clear_req SHALL take priority over req0/req1 in the same cycle: no grant, go to CLEAR, latch clear_colour, set the sweep counters to (0,0).
REQ-021 In IDLE without clear_req, at most one grant per cycle SHALL be issued, round-robin: the sole requester wins; if both request, the one not granted last wins.
REQ-022 The last-granted pointer SHALL reset to 1, so requester 0 wins the first contention, and SHALL update only on a grant.
REQ-023 A granted pixel SHALL appear on out_x/out_y/out_colour with out_plot=1 exactly one cycle after the grant (latency 1).
REQ-024 A granted pixel with x>=X_MAX or y>=Y_MAX SHALL still be granted, but SHALL drive out_plot=0 and oob=1 one cycle later.
REQ-025 In CLEAR, one pixel per cycle SHALL be emitted: X increments; at X_MAX-1 it wraps to 0 and Y increments.
REQ-026 In CLEAR, every emitted pixel SHALL carry the latched colour with out_plot=1.
REQ-027 The fill SHALL be exactly X_MAX*Y_MAX writes (76800 for 320x240), ending at (X_MAX-1, Y_MAX-1), then return to IDLE.
REQ-028 In CLEAR, gnt0 and gnt1 SHALL be 0; clear_req and clear_colour SHALL be ignored.
REQ-029 clear_busy SHALL go high the cycle after acceptance and fall the cycle after the last fill pixel is output.
REQ-030 out_plot SHALL be 0 in every cycle with no grant and no fill pixel; out_x/out_y/out_colour SHALL hold their last value.

Reset
REQ-031 Asserting resetn low SHALL immediately force: state IDLE, sweep counters 0, out_x/out_y/out_colour 0, out_plot 0, oob 0, clear_busy 0, pointer 1.
REQ-032 A reset during CLEAR SHALL abort the fill with no further writes; after reset release the block SHALL accept new requests in the first clock.

Structure
REQ-033 Package vga_pkg SHALL hold the X_MAX/Y_MAX constants per resolution, the coordinate and colour widths, and the state enum (IDLE, CLEAR).
REQ-034 The round-robin decision (two requests, pointer -> two grants, pointer update) SHALL be a sub-module named rr_arbiter2.

Verification
REQ-035 req0=1 only, (10,20,0xF00) -> gnt0 in the same cycle; next cycle out_plot=1, out=(10,20,0xF00).
REQ-036 req0 and req1 both held for 4 cycles after reset -> grants 0,1,0,1; outputs alternate accordingly.
REQ-037 clear_req with clear_colour=0x00F, req1 high in the same cycle -> gnt1=0; 76800 out_plot cycles; first (0,0), last (319,239); clear_busy high for 76800 cycles; then gnt1 issued.
REQ-038 req0 with (320,5) -> gnt0=1; next cycle out_plot=0, oob=1.
REQ-039 resetn low at fill pixel 1000 -> outputs 0 and clear_busy 0 immediately; after release req0 is granted in the first cycle.
REQ-040 RESOLUTION="160x120" fill -> 19200 writes; last (159,119); (160,0) from a requester is flagged oob.
